// File: rtl/fir_mac_filter_pkg.sv
// Shared types and constants for the 8-tap FIR MAC engine.
// FIR_SATURATE_EN selects clamping (defined) or two's-complement wrap (default) of the output.
package fir_pkg;

    localparam int NTAPS = 8;
    localparam int DW    = 24;
    localparam int CW    = 16;
    localparam int ACCW  = 43;
    localparam int FRAC  = 15;
    localparam int PW    = DW + CW;
    localparam int KW    = $clog2(NTAPS);

    typedef enum logic [1:0] {IDLE, MAC, DONE} fir_state_t;

    typedef logic signed [DW-1:0]   sample_t;
    typedef logic signed [CW-1:0]   coeff_t;
    typedef logic signed [ACCW-1:0] acc_t;

    // Reduce the already-shifted accumulator to the output sample width.
    function automatic sample_t reduce_result(input acc_t v);
`ifdef FIR_SATURATE_EN
        if (v > acc_t'(2**(DW-1) - 1))
            return {1'b0, {(DW-1){1'b1}}};
        else if (v < acc_t'(-(2**(DW-1))))
            return {1'b1, {(DW-1){1'b0}}};
        else
            return v[DW-1:0];
`else
        return v[DW-1:0];
`endif
    endfunction

endpackage

// File: rtl/fir_mac_filter_if.sv
// Sample/tap bus between the upstream source, the FIR engine and the sample consumer.
interface fir_mac_filter_if;
    import fir_pkg::*;

    logic [NTAPS*CW-1:0] taps_in;
    logic                in_valid;
    logic                in_ready;
    sample_t             sample_in;
    logic                out_valid;
    sample_t             sample_out;

    modport master (
        output taps_in, in_valid, sample_in,
        input  in_ready, out_valid, sample_out
    );

    modport slave (
        input  taps_in, in_valid, sample_in,
        output in_ready, out_valid, sample_out
    );

endinterface

// File: rtl/fir_mac_filter_mac_unit.sv
// Single signed multiplier feeding a clearable accumulator; kept separate so the
// multiply maps cleanly onto one DSP block.
module fir_mac_unit
    import fir_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    clear,
    input  logic    en,
    input  sample_t a,
    input  coeff_t  b,
    output acc_t    acc
);

    logic signed [PW-1:0] product;

    assign product = a * b;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset || clear)
            acc <= '0;
        else if (en)
            acc <= acc + acc_t'(product);
    end

endmodule

// File: rtl/fir_mac_filter.sv
// 8-tap FIR: one sample per request, 8 time-shared MAC cycles, registered output pulse.
module fir_mac_filter
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    fir_mac_filter_if.slave   bus
);

    fir_state_t        state, state_next;
    sample_t           xline  [NTAPS];
    coeff_t            taps_q [NTAPS];
    logic [KW-1:0]     k;
    logic              accept, mac_clr, mac_en, in_ready;
    logic              out_valid;
    sample_t           sample_out;
    acc_t              acc;

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.sample_out = sample_out;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !reset;
                accept   = bus.in_valid && !reset;
                if (accept) begin
                    mac_clr    = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (k == KW'(NTAPS-1))
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the delay line is reset explicitly because an aborted computation
    // must not leak old samples into the next result.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                xline[i]  <= '0;
                taps_q[i] <= '0;
            end
            k          <= '0;
            out_valid  <= 1'b0;
            sample_out <= '0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                xline[0] <= bus.sample_in;
                for (int i = NTAPS-1; i > 0; i--)
                    xline[i] <= xline[i-1];
                for (int i = 0; i < NTAPS; i++)
                    taps_q[i] <= coeff_t'(bus.taps_in[(NTAPS-1-i)*CW +: CW]);
                k <= '0;
            end
            if (mac_en)
                k <= k + 1'b1;
            if (state == DONE) begin
                sample_out <= reduce_result(acc >>> FRAC);
                out_valid  <= 1'b1;
            end
        end
    end

    fir_mac_unit u_mac (
        .clk   (clk),
        .reset (reset),
        .clear (mac_clr),
        .en    (mac_en),
        .a     (xline[k]),
        .b     (taps_q[k]),
        .acc   (acc)
    );

endmodule

// File: tb/tb_fir_mac_filter.sv
// Self-checking bench for fir_mac_filter: directed cases plus randomized samples
// against an arithmetic reference model of the FIR sum.
module tb_fir_mac_filter;
    import fir_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fir_mac_filter_if bus();

    fir_mac_filter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int     n_cmp = 0;
    int     n_bad = 0;
    longint hist [NTAPS];
    longint snap [NTAPS];
    longint exp_y;
    longint last_out;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // y = floor(sum(x[k]*h[k]) / 2^15), then reduced to 24 bits
    function automatic longint ref_output();
        longint sum, y;
        sum = 0;
        for (int i = 0; i < NTAPS; i++)
            sum += hist[i] * snap[i];
        y = sum >>> FRAC;
`ifdef FIR_SATURATE_EN
        if (y > 8388607)       y = 8388607;
        else if (y < -8388608) y = -8388608;
`else
        y = y & 64'hFFFFFF;
        if (y >= 8388608) y = y - 16777216;
`endif
        return y;
    endfunction

    task automatic model_accept(input longint x, input logic [NTAPS*CW-1:0] t);
        coeff_t c;
        for (int i = NTAPS-1; i > 0; i--)
            hist[i] = hist[i-1];
        hist[0] = x;
        for (int i = 0; i < NTAPS; i++) begin
            c = t[(NTAPS-1-i)*CW +: CW];
            snap[i] = c;
        end
        exp_y = ref_output();
    endtask

    task automatic model_reset();
        for (int i = 0; i < NTAPS; i++)
            hist[i] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.sample_in = '0;
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",   bus.in_ready,   0);
        check("rst_out_valid",  bus.out_valid,  0);
        check("rst_sample_out", bus.sample_out, 0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);
    endtask

    // Present one sample, wait for acceptance and the result; called at a negedge.
    task automatic run_sample(input longint x, input logic [NTAPS*CW-1:0] t,
                              input string tag, input int chg_at,
                              input logic [NTAPS*CW-1:0] t2);
        int w, lat;
        bit seen;
        bus.sample_in = sample_t'(x);
        bus.taps_in   = t;
        bus.in_valid  = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) begin
            check({tag, "_accept_timeout"}, bus.in_ready, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(x, t);
        lat  = 0;
        seen = 1'b0;
        while (lat < 20) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
            bus.in_valid = 1'b0;
            if (chg_at >= 0 && lat == chg_at)
                bus.taps_in = t2;
            @(posedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        check({tag, "_latency"}, lat, 9);
        if (seen) begin
            last_out = bus.sample_out;
            check({tag, "_value"}, bus.sample_out, exp_y);
            @(negedge clk);
            check({tag, "_pulse_width"}, bus.out_valid, 0);
        end
    endtask

    logic [NTAPS*CW-1:0] t, t2;
    sample_t             s;
    longint              cur;
    int                  w, cnt;

    initial begin
        bus.in_valid  = 1'b0;
        bus.sample_in = '0;
        bus.taps_in   = '0;
        last_out      = 0;
        model_reset();
        do_reset();

        // single-tap gain of 0.5
        t = '0;
        t[127:112] = 16'h4000;
        run_sample(1000, t, "gain_pos", -1, t);
        check("gain_pos_const", last_out, 500);
        run_sample(-1000, t, "gain_neg", -1, t);
        check("gain_neg_const", last_out, -500);

        // impulse response walks out h[k]*2
        do_reset();
        t = '0;
        for (int i = 0; i < NTAPS; i++)
            t[(NTAPS-1-i)*CW +: CW] = 16'((i+1) * 256);
        for (int i = 0; i < NTAPS; i++) begin
            run_sample((i == 0) ? 64'sh10000 : 0, t, "impulse", -1, t);
            check("impulse_const", last_out, (i+1) * 512);
        end

        // full-scale overflow
        do_reset();
        t = {NTAPS{16'h7FFF}};
        for (int i = 0; i < NTAPS; i++)
            run_sample(64'sh7FFFFF, t, "overflow", -1, t);
`ifdef FIR_SATURATE_EN
        check("overflow_const", last_out, 8388607);
`else
        check("overflow_const", last_out, -2056);
`endif

        // taps changed mid-computation must not disturb the in-flight result
        do_reset();
        t = '0;
        t[127:112] = 16'h4000;
        run_sample(1000, t, "tapchg_inflight", 3, '0);
        check("tapchg_inflight_const", last_out, 500);
        run_sample(1000, '0, "tapchg_next", -1, '0);
        check("tapchg_next_const", last_out, 0);

        // reset during MAC aborts and clears the delay line
        bus.sample_in = sample_t'(2000);
        bus.taps_in   = t;
        bus.in_valid  = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
        check("midrst_no_out_valid", cnt, 0);
        t = '0;
        t[127:112] = 16'h4000;
        t[111:96]  = 16'h4000;
        run_sample(1000, t, "midrst_cleared", -1, t);
        check("midrst_cleared_const", last_out, 500);

        // in_valid held continuously: one acceptance every 10 cycles
        t = {$urandom, $urandom, $urandom, $urandom};
        bus.taps_in  = t;
        s = sample_t'($urandom);
        cur = s;
        bus.sample_in = s;
        bus.in_valid  = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("hs_first_ready", bus.in_ready, 1);
        for (int idx = 0; idx < 20; idx++) begin
            @(posedge clk);
            model_accept(cur, t);
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    s = sample_t'($urandom);
                    cur = s;
                    bus.sample_in = s;
                end
                if (c < 10) begin
                    check("hs_busy_ready", bus.in_ready, 0);
                end else begin
                    check("hs_out_valid", bus.out_valid, 1);
                    check("hs_value", bus.sample_out, exp_y);
                    check("hs_ready_again", bus.in_ready, 1);
                end
            end
        end
        bus.in_valid = 1'b0;
        @(negedge clk);

        // random samples and taps, some with mid-flight tap changes
        for (int n = 0; n < 25; n++) begin
            t  = {$urandom, $urandom, $urandom, $urandom};
            t2 = {$urandom, $urandom, $urandom, $urandom};
            s  = sample_t'($urandom);
            cur = s;
            run_sample(cur, t, "random", ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : -1, t2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_mac_filter.md
Name: fir_mac_filter

Overview:
- 8-tap FIR engine; sits directly downstream of the coefficient tap fetcher, consuming its packed 128-bit tap bus.
- Filters one 24-bit signed audio sample per request using a single time-shared multiplier: 8 MAC cycles per sample.
- Emits one registered 24-bit filtered sample with a valid pulse.

Parameters:
- NTAPS, 8, number of taps; the tap bus is NTAPS*CW bits wide.
- DW, 24, sample width, signed two's complement.
- CW, 16, coefficient width, signed Q1.15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- taps_in  in  NTAPS*CW  packed coefficients {h0,h1,...,h7}; h0 in [127:112], h7 in [15:0]
- in_valid  in  1  sample_in is valid
- in_ready  out  1  block can accept a sample this cycle
- sample_in  in  DW  new audio sample x[n]
- out_valid  out  1  single-cycle pulse: sample_out holds a new result
- sample_out  out  DW  filtered sample y[n]

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset values: in_ready=0 during reset and 1 the cycle after; out_valid=0; sample_out=0; delay line x[0..7]=0; state=IDLE; accumulator=0; tap index k=0.
- State machine:
  - IDLE: in_ready=1. On in_valid&&in_ready (edge E0): shift delay line (x[i]<=x[i-1], x[0]<=sample_in), snapshot taps_in into an internal tap register, acc<=0, k<=0, go to MAC.
  - MAC: in_ready=0. Each edge: acc<=acc+x[k]*h[k], k<=k+1. At k==7 (edge E8), go to DONE.
  - DONE: in_ready=0. At E9: sample_out<=result, out_valid<=1, go to IDLE.
- Latency and throughput: out_valid is high for exactly one cycle, between E9 and E10. The next sample can be accepted at E10 at the earliest (1 sample per 10 clocks).
- in_valid is ignored outside IDLE. No buffering; the upstream source must hold in_valid until it is accepted.
- Arithmetic:
  - Product is DW+CW = 40 bits signed.
  - Accumulator is 43 bits signed (3 guard bits for 8 products).
  - Result = acc >>> 15 (arithmetic shift, floor), reduced to 24 bits per FIR_SATURATE_EN.
- Tap snapshot: changes on taps_in during MAC or DONE do not affect the in-flight result. They take effect at the next acceptance.
- Reset mid-operation: reset in MAC or DONE aborts the computation. No out_valid is produced, and the delay line is cleared.
- Delay line: holds the 8 most recent accepted samples. It does not advance without an accepted sample.

Optional Feature:
- Macro: FIR_SATURATE_EN
- Defined: the shifted accumulator is clamped to [-8388608, 8388607] (0x800000..0x7FFFFF) before output.
- Undefined: the low 24 bits of the shifted accumulator are taken (two's-complement wrap).

Decomposition:
- Package fir_pkg:
  - NTAPS, DW, CW, ACCW=43, FRAC=15
  - state enum fir_state_t {IDLE, MAC, DONE}
  - sample_t/coeff_t typedefs
- Sub-module fir_mac_unit: combinational signed multiply plus registered accumulate with clear/enable. It isolates the DSP-block inference.
- Delay line, tap snapshot and FSM stay in the top module.

Test Plan:
- Single-tap gain: taps h0=0x4000, others 0; sample_in=1000 -> sample_out=500, out_valid exactly 9 edges after acceptance. Then sample_in=-1000 -> sample_out=-500.
- Impulse response: taps h0..h7 = 0x0100,0x0200,...,0x0800; inputs 0x010000 then seven zeros -> outputs 0x0200,0x0400,...,0x1000 in order (h[k]*2).
- Overflow: all taps 0x7FFF; eight inputs 0x7FFFFF -> eighth output 0x7FFFFF with FIR_SATURATE_EN; without it, the wrapped low 24 bits of (acc>>>15).
- Tap change mid-MAC: h0=0x4000 (others 0); accept 1000; change taps_in to all zeros 3 cycles after acceptance -> output 500. Next sample 1000 -> output 0.
- Handshake: in_valid held high continuously -> in_ready low during MAC/DONE, one acceptance per 10 cycles, no dropped or duplicated samples over 20 inputs, checked against a reference model.
- Reset mid-MAC: assert reset 4 cycles after acceptance -> no out_valid. Then h0=0x4000, h1=0x4000 with a single input 1000 -> output 500, confirming the delay line was cleared.
